fp_i2f: RTL
===========

// Module: fp_i2f
// PURPOSE
//  Sequential integer-to-floating-point converter; inverse of the FPU's float-to-int path.
//  Accepts a signed or unsigned integer plus a rounding mode and returns an IEEE-754 result with flags.
//  Latency is fixed at 3 cycles. Instantiated in the FPU execute stage beside the F2I converter.
// PARAMETERS
//  FP_FORMAT   FP32   fp_format_e; target format. FP_WIDTH/EXP_WIDTH/MANT_WIDTH come from fp_pkg functions.
//  INT_FORMAT  INT32  int_format_e; source width INT_WIDTH = int_width(INT_FORMAT).
// PORTS
//  clk_i     in   1           clock; all state updates on the rising edge
//  rst_ni    in   1           reset, asynchronous, active-low
//  a_i       in   INT_WIDTH   integer operand; sampled when the operation is accepted
//  signed_i  in   1           1: a_i is two's complement; 0: a_i is unsigned
//  start_i   in   1           request; accepted only in IDLE
//  rnd_i     in   roundmode_e rounding mode (RNE/RTZ/RDN/RUP/RMM); sampled with a_i
//  result_o  out  FP_WIDTH    converted value; registered, held until the next done_o
//  flags_o   out  status_t    NV=0, DZ=0, UF=0 always; OF and NX as defined below; held with result_o
//  busy_o    out  1           high from acceptance until the cycle done_o pulses
//  done_o    out  1           single-cycle pulse; result_o and flags_o are valid from this cycle on
// BEHAVIOUR
//  Reset: state=IDLE; result_o=0, flags_o=0, busy_o=0, done_o=0. Internal regs cleared.
//  Reset asserted mid-operation aborts the conversion; no done_o is produced for it.
//  FSM IDLE -> ABS -> NORM -> RND -> IDLE.
//   IDLE: on start_i, register a_i, signed_i, rnd_i; set busy_o.
//   ABS: sign = signed_i & a[MSB]. mag = sign ? -a : a, held as INT_WIDTH-bit unsigned, so
//    most-negative signed becomes 2^(INT_WIDTH-1). Zero detect.
//   NORM: lz = LZC(mag); shifted = mag << lz (MSB becomes the implicit 1);
//    unbiased exponent e = INT_WIDTH-1-lz.
//   RND: mant = shifted[W-2 -: MANT_WIDTH]; guard = the next bit down; sticky = OR of all lower bits.
//    NX = guard|sticky.
//    Round-up: RNE g&(lsb|s); RTZ 0; RDN sign&(g|s); RUP ~sign&(g|s); RMM g.
//    A carry out of the mantissa increment gives mant=0 and e+1.
//    If e+BIAS >= 2^EXP_WIDTH-1, the result overflows: OF=1, NX=1, and the value is chosen by mode:
//     RNE/RMM -> +/-inf; RTZ -> +/-max finite;
//     RDN -> -inf if negative, else +max finite; RUP -> +inf if positive, else -max finite.
//    Zero input -> +0, flags 0.
//    Pack {sign, e+BIAS, mant}, then register result_o/flags_o and pulse done_o.
//  Latency: start_i accepted at edge N -> done_o high in cycle N+3.
//   busy_o=1 during cycles N+1..N+3. Back-to-back starts give one result per 4 cycles.
//  start_i while busy_o=1: ignored; no queueing.
//   start_i in the same cycle done_o pulses: also ignored, because the FSM is not yet in IDLE.
//  Denormals are never produced; UF is always 0.
//  The integer range always fits the exponent except for narrow targets (e.g. INT32->FP16),
//   where the overflow path is required.
// STRUCTURE
//  fp_pkg already supplies fp_format_e, int_format_e, roundmode_e, status_t, fp_width/exp_bits/man_bits/int_width.
//  Add to fp_pkg: function fp_max_finite(fmt, sign) and fp_inf(fmt, sign), shared with F2I and other units.
//  FSM state enum is local to this module (i2f_state_e).
//  One sub-module: fp_lzc #(WIDTH) — combinational leading-zero count with an all-zero flag;
//   reusable by the adder and multiplier normalizers.
// TESTING
//  FP32/INT32, signed, a=0xFFFFFFFF (-1), RNE -> 0xBF800000, flags 0, done_o exactly 3 cycles after start.
//  FP32/INT32, signed, a=0x7FFFFFFF: RNE -> 0x4F000000 NX=1; RTZ -> 0x4EFFFFFF NX=1.
//  FP32/INT32, signed a=0x80000000 -> 0xCF000000 NX=0; unsigned a=0x80000000 -> 0x4F000000 NX=0.
//  FP16/INT32, unsigned a=0xFFFFFFFF: RNE -> 0x7C00 OF=1 NX=1; RTZ and RDN -> 0x7BFF OF=1 NX=1; RUP -> 0x7C00.
//  a=0 in all modes -> 0x00000000 flags 0.
//   Second start_i while busy is ignored: exactly one done_o, with the first operand's result.
//  Deassert rst_ni in NORM -> outputs return to 0, no done_o.
//   A new start after reset release completes normally with latency 3.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FPU types and format helpers used by the conversion and arithmetic units.
package fp_pkg;

  typedef enum logic [1:0] {
    FP32    = 2'd0,
    FP64    = 2'd1,
    FP16    = 2'd2,
    FP16ALT = 2'd3
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  function automatic int unsigned int_width(int_format_e ifmt);
    case (ifmt)
      INT8:    return 8;
      INT16:   return 16;
      INT64:   return 64;
      default: return 32;
    endcase
  endfunction

  // Largest finite magnitude with the given sign, right-aligned in 64 bits.
  function automatic logic [63:0] fp_max_finite(fp_format_e fmt, logic sign);
    int unsigned e;
    int unsigned m;
    logic [63:0] r;
    e = exp_bits(fmt);
    m = man_bits(fmt);
    r = ((64'd1 << e) - 64'd2) << m;
    r = r | ((64'd1 << m) - 64'd1);
    r = r | (64'(sign) << (e + m));
    return r;
  endfunction

  // Infinity with the given sign, right-aligned in 64 bits.
  function automatic logic [63:0] fp_inf(fp_format_e fmt, logic sign);
    int unsigned e;
    int unsigned m;
    logic [63:0] r;
    e = exp_bits(fmt);
    m = man_bits(fmt);
    r = ((64'd1 << e) - 64'd1) << m;
    r = r | (64'(sign) << (e + m));
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter with an all-zero flag.
module fp_lzc #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     data_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 zero_o
);

  // Scan upward so the highest set bit writes the final count; all-zero yields WIDTH.
  always_comb begin
    cnt_o = CNT_WIDTH'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/fp_i2f.sv
// Sequential integer-to-float converter with a fixed three-cycle latency.
module fp_i2f
  import fp_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT  = FP32,
  parameter int_format_e INT_FORMAT = INT32,
  localparam int unsigned INT_WIDTH = int_width(INT_FORMAT),
  localparam int unsigned FP_WIDTH  = fp_width(FP_FORMAT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [INT_WIDTH-1:0] a_i,
  input  logic                 signed_i,
  input  logic                 start_i,
  input  roundmode_e           rnd_i,
  output logic [FP_WIDTH-1:0]  result_o,
  output status_t              flags_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned EXP_WIDTH  = exp_bits(FP_FORMAT);
  localparam int unsigned MANT_WIDTH = man_bits(FP_FORMAT);
  localparam int unsigned BIAS       = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int unsigned CNT_WIDTH  = $clog2(INT_WIDTH + 1);
  // Fraction below the implicit one, padded so guard/sticky always exist.
  localparam int unsigned EXT_WIDTH  = INT_WIDTH + MANT_WIDTH + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAbs  = 2'd1,
    StNorm = 2'd2,
    StRnd  = 2'd3
  } i2f_state_e;

  i2f_state_e           state_q;
  logic [INT_WIDTH-1:0] a_q;
  logic                 signed_q;
  roundmode_e           rnd_q;
  logic                 sign_q;
  logic [INT_WIDTH-1:0] mag_q;
  logic [FP_WIDTH-1:0]  result_q;
  status_t              flags_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 abs_sign;
  logic [INT_WIDTH-1:0] abs_mag;
  logic [CNT_WIDTH-1:0] lz;
  logic                 mag_zero;
  logic [INT_WIDTH-2:0] frac;
  logic [EXT_WIDTH-1:0] ext;
  logic [MANT_WIDTH-1:0] mant;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [MANT_WIDTH:0]  mant_sum;
  logic [31:0]          exp_biased;
  logic                 overflow;
  logic [FP_WIDTH-1:0]  rnd_res;
  status_t              rnd_flags;

  fp_lzc #(
    .WIDTH    (INT_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_lzc (
    .data_i(mag_q),
    .cnt_o (lz),
    .zero_o(mag_zero)
  );

  // Sign and magnitude; the most-negative input maps to 2^(INT_WIDTH-1) as unsigned.
  always_comb begin
    abs_sign = signed_q & a_q[INT_WIDTH-1];
    abs_mag  = abs_sign ? -a_q : a_q;
  end

  // Normalize, round and pack from the registered magnitude.
  always_comb begin
    frac       = (INT_WIDTH - 1)'(mag_q << lz);
    ext        = {frac, {(MANT_WIDTH + 2){1'b0}}};
    mant       = ext[EXT_WIDTH-1 -: MANT_WIDTH];
    guard      = ext[INT_WIDTH];
    sticky     = |ext[INT_WIDTH-1:0];
    case (rnd_q)
      RNE:     round_up = guard & (mant[0] | sticky);
      RTZ:     round_up = 1'b0;
      RDN:     round_up = sign_q & (guard | sticky);
      RUP:     round_up = ~sign_q & (guard | sticky);
      RMM:     round_up = guard;
      default: round_up = 1'b0;
    endcase
    mant_sum   = {1'b0, mant} + {{MANT_WIDTH{1'b0}}, round_up};
    // A mantissa carry leaves the low bits zero and bumps the exponent.
    exp_biased = 32'(INT_WIDTH - 1) - 32'(lz) + 32'(BIAS) + 32'(mant_sum[MANT_WIDTH]);
    overflow   = exp_biased >= 32'((1 << EXP_WIDTH) - 1);

    rnd_flags    = '0;
    rnd_flags.nx = guard | sticky;
    rnd_res      = {sign_q, exp_biased[EXP_WIDTH-1:0], mant_sum[MANT_WIDTH-1:0]};
    if (mag_zero) begin
      rnd_res   = '0;
      rnd_flags = '0;
    end else if (overflow) begin
      rnd_flags.of = 1'b1;
      rnd_flags.nx = 1'b1;
      case (rnd_q)
        RTZ:     rnd_res = FP_WIDTH'(fp_max_finite(FP_FORMAT, sign_q));
        RDN:     rnd_res = sign_q ? FP_WIDTH'(fp_inf(FP_FORMAT, 1'b1))
                                  : FP_WIDTH'(fp_max_finite(FP_FORMAT, 1'b0));
        RUP:     rnd_res = sign_q ? FP_WIDTH'(fp_max_finite(FP_FORMAT, 1'b1))
                                  : FP_WIDTH'(fp_inf(FP_FORMAT, 1'b0));
        default: rnd_res = FP_WIDTH'(fp_inf(FP_FORMAT, sign_q));
      endcase
    end
  end

  // Control FSM; the packed result is registered on leaving StNorm so done_o lands in StRnd.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_q      <= '0;
      signed_q <= 1'b0;
      rnd_q    <= RNE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            a_q      <= a_i;
            signed_q <= signed_i;
            rnd_q    <= rnd_i;
            busy_q   <= 1'b1;
            state_q  <= StAbs;
          end
        end
        StAbs: begin
          sign_q  <= abs_sign;
          mag_q   <= abs_mag;
          state_q <= StNorm;
        end
        StNorm: begin
          result_q <= rnd_res;
          flags_q  <= rnd_flags;
          done_q   <= 1'b1;
          state_q  <= StRnd;
        end
        StRnd: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result_o = result_q;
  assign flags_o  = flags_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
